// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: operand-select encodings and the pipeline tracking slot.
// Slot addresses are stored at FWD_AW_MAX bits, so instantiations must keep AW <= FWD_AW_MAX.
// No latency or backpressure: this file holds only declarations and a pure match helper.
package fwd_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;
    localparam logic [1:0] FWD_IMM = 2'b11;

    localparam int FWD_AW_MAX = 8;

    typedef logic [FWD_AW_MAX-1:0] fwd_dst_t;

    typedef struct packed {
        logic     valid;
        fwd_dst_t dst;
        logic     we;
        logic     load;
    } fwd_slot_t;

    // Register 0 is hardwired zero, so it never produces a forwarding hit.
    function automatic logic slot_match(input fwd_slot_t s, input fwd_dst_t a);
        return s.valid && s.we && (s.dst == a) && (a != '0);
    endfunction

endpackage

// File: rtl/fwd_port_match.sv
// Per-operand priority match against the EX and MEM slots; youngest producer wins.
// Latency: purely combinational.
// Backpressure: none; load_hit tells the top that this operand needs a load-use stall.
module fwd_port_match
    import fwd_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] addr,
    input  logic          used,
    input  fwd_slot_t     ex,
    input  fwd_slot_t     mem,
    output logic [1:0]    sel,
    output logic          load_hit
);

    fwd_dst_t a;
    logic     ex_hit;
    logic     mem_hit;
    logic     unused_mem_load;

    assign a               = fwd_dst_t'(addr);
    assign ex_hit          = used && slot_match(ex, a);
    assign mem_hit         = used && slot_match(mem, a);
    assign unused_mem_load = mem.load;

    // EX result will sit in MEM next cycle; MEM result will sit in WB.
    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
    end

    assign load_hit = ex_hit && ex.load;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection over EX/MEM/WB tracking slots; FWD_STALL_CNT_EN adds stall_cnt.
// Latency: stall is combinational from decode; fwd_sel/sd_sel are registered and aligned with EX.
// Backpressure: stall holds fetch/decode for one cycle per load-use pair; flush overrides stall.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int AW     = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NPORTS*AW-1:0]   id_src,
    input  logic [NPORTS-1:0]      id_src_used,
    input  logic                   id_imm,
    input  logic [AW-1:0]          id_dst,
    input  logic                   id_we,
    input  logic                   id_load,
    input  logic                   flush,
    output logic                   stall,
    output logic [2*NPORTS-1:0]    fwd_sel,
`ifdef FWD_STALL_CNT_EN
    output logic [15:0]            stall_cnt,
`endif
    output logic [1:0]             sd_sel
);

    fwd_slot_t           ex_q;
    fwd_slot_t           mem_q;
    fwd_slot_t           wb_q;
    fwd_slot_t           ex_d;
    logic [1:0]          psel [NPORTS];
    logic [NPORTS-1:0]   lhit;
    logic                issue;
    logic [2*NPORTS-1:0] fwd_d;
    logic [1:0]          sd_d;
    logic                unused_wb;

    // WB is tracked for completeness of the pipeline picture; nothing forwards from it yet.
    assign unused_wb = ^wb_q;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic used;
        if (p == 1) begin : g_p1
            // A store's register operand on port 1 still needs its value as store data.
            assign used = id_src_used[p] | id_imm;
        end else begin : g_pn
            assign used = id_src_used[p];
        end
        fwd_port_match #(.AW(AW)) u_match (
            .addr     (id_src[p*AW +: AW]),
            .used     (used),
            .ex       (ex_q),
            .mem      (mem_q),
            .sel      (psel[p]),
            .load_hit (lhit[p])
        );
    end

    assign stall = id_valid && !flush && (|lhit);
    assign issue = id_valid && !flush && !stall;

    always_comb begin
        ex_d  = '0;
        fwd_d = '0;
        sd_d  = FWD_RF;
        if (issue) begin
            ex_d.valid = 1'b1;
            ex_d.dst   = fwd_dst_t'(id_dst);
            ex_d.we    = id_we;
            ex_d.load  = id_load;
            for (int p = 0; p < NPORTS; p++) begin
                fwd_d[2*p +: 2] = psel[p];
            end
            if (id_imm) begin
                fwd_d[2 +: 2] = FWD_IMM;
                sd_d          = psel[1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_sel <= '0;
            sd_sel  <= FWD_RF;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            fwd_sel <= fwd_d;
            sd_sel  <= sd_d;
        end
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
